out_port_fifo: RTL

- Output-side buffer directly downstream of the CPU output port.
- Captures every byte the CPU presents on its output bus while the output-enable strobe is high.
- Holds captured bytes in a small circular FIFO and drains them to an external consumer over a valid/ready handshake.
- Lets the CPU issue output instructions back to back without any stall path; overflow is flagged, not back-pressured.

---
 rtl/out_port_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/out_port_fifo.sv
// Circular FIFO that buffers CPU output-port bytes and drains them over valid/ready.
// Define OUT_PORT_FIFO_DROP_CNT_EN to add a saturating dropped-push counter (o_drop_cnt).
module out_port_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              OUT_EN,
    input  logic [DATA_W-1:0] OUT_DATA,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ovf,
    input  logic              ovf_clr
`ifdef OUT_PORT_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        o_drop_cnt
`endif
);

    localparam int              DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH_I];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;

    logic push;
    logic pop;
    logic drop;

    // Status is derived only from the registered count, never from the strobes.
    assign o_count = count_q;
    assign o_full  = (count_q == DEPTH);
    assign o_empty = (count_q == '0);
    assign o_valid = ~o_empty;
    assign o_data  = mem[rd_ptr_q];
    assign o_ovf   = ovf_q;

    assign pop  = o_valid & i_ready;
    assign push = OUT_EN & (~o_full | pop);
    assign drop = OUT_EN & o_full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never cleared; pointers alone define what is live.
    always_ff @(posedge CLK) begin
        if (push && !RESET) begin
            mem[wr_ptr_q] <= OUT_DATA;
        end
    end

`ifdef OUT_PORT_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
